// File: rtl/coef_pkg.sv
// Shared constants and types for the coefficient commit controller.
// The bands are committed in the order low, mid, high.
package coef_pkg;
    localparam int COEF_W = 16;
    localparam int NBANDS = 3;
    localparam int NCOEF  = 5;

    localparam logic [15:0] Q14_ONE = 16'h4000;

    localparam int BAND_LOW  = 0;
    localparam int BAND_MID  = 1;
    localparam int BAND_HIGH = 2;

    // First word (b0) of each band inside the packed set
    localparam int LOW_W0  = 0;
    localparam int MID_W0  = 5;
    localparam int HIGH_W0 = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SAMPLE,
        ST_COMMIT_LOW,
        ST_COMMIT_MID,
        ST_COMMIT_HIGH,
        ST_DONE
    } state_e;

    function automatic int band_word0(input int band);
        case (band)
            BAND_MID:  return MID_W0;
            BAND_HIGH: return HIGH_W0;
            default:   return LOW_W0;
        endcase
    endfunction
endpackage

// File: rtl/coef_bank_reg.sv
// Five-word coefficient register for one biquad band.
// Reset value is the passthrough filter: b0 = unity, every other word zero.
import coef_pkg::*;

module coef_bank_reg #(
    parameter int               COEF_W = 16,
    parameter logic [COEF_W-1:0] UNITY = COEF_W'(Q14_ONE)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ld_i,
    input  logic [NCOEF*COEF_W-1:0]   d_i,
    output logic [NCOEF*COEF_W-1:0]   q_o
);
    localparam logic [NCOEF*COEF_W-1:0] RST_VAL = {{((NCOEF-1)*COEF_W){1'b0}}, UNITY};

    logic [NCOEF*COEF_W-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     q_q <= RST_VAL;
        else if (ld_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

// File: rtl/coef_commit_ctrl.sv
// Glitch-free coefficient update for a three-band biquad chain: a new set is
// captured into a shadow, latched on a sample strobe, then committed band by band.
import coef_pkg::*;

module coef_commit_ctrl #(
    parameter int COEF_W      = coef_pkg::COEF_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             upd_valid,
    input  logic [NBANDS*NCOEF*COEF_W-1:0]   upd_coefs,
    input  logic                             sample_strobe,
    input  logic [NBANDS-1:0]                band_busy,
    output logic [NBANDS*NCOEF*COEF_W-1:0]   act_coefs,
    output logic                             pending,
    output logic                             commit_done,
    output logic                             superseded,
    output logic                             timeout_err
);
    localparam int SET_W  = NBANDS*NCOEF*COEF_W;
    localparam int BAND_W = NCOEF*COEF_W;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC-1);
    localparam logic [COEF_W-1:0] UNITY  = {2'b01, {(COEF_W-2){1'b0}}};

    state_e             state_q, state_d;
    logic [SET_W-1:0]   shadow_q, work_q;
    logic               full_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               sup_q;
    logic               xfer;
    logic               in_commit;
    logic [1:0]         cur;
    state_e             nxt;
    logic [NBANDS-1:0]  band_ld;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        xfer      = 1'b0;
        in_commit = 1'b0;
        cur       = 2'(BAND_LOW);
        nxt       = ST_IDLE;
        band_ld   = '0;
        case (state_q)
            ST_IDLE:        if (full_q) state_d = ST_WAIT_SAMPLE;
            ST_WAIT_SAMPLE: if (sample_strobe) begin
                state_d = ST_COMMIT_LOW;
                xfer    = 1'b1;
                cnt_d   = '0;
            end
            ST_COMMIT_LOW:  begin in_commit = 1'b1; cur = 2'(BAND_LOW);  nxt = ST_COMMIT_MID;  end
            ST_COMMIT_MID:  begin in_commit = 1'b1; cur = 2'(BAND_MID);  nxt = ST_COMMIT_HIGH; end
            ST_COMMIT_HIGH: begin in_commit = 1'b1; cur = 2'(BAND_HIGH); nxt = ST_DONE;        end
            ST_DONE:        state_d = full_q ? ST_WAIT_SAMPLE : ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        // A busy band is waited on until the counter expires, then forced through
        if (in_commit) begin
            if (!band_busy[cur] || cnt_q == CNT_MAX) begin
                band_ld[cur] = 1'b1;
                cnt_d        = '0;
                state_d      = nxt;
                if (band_busy[cur]) err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            work_q   <= '0;
            full_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            sup_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Overwriting on the transfer edge is not a supersede: the old set moves on
            sup_q   <= upd_valid & full_q & ~xfer;
            if (upd_valid) begin
                shadow_q <= upd_coefs;
                full_q   <= 1'b1;
            end else if (xfer) begin
                full_q <= 1'b0;
            end
            if (xfer) work_q <= shadow_q;
        end
    end

    for (genvar b = 0; b < NBANDS; b++) begin : g_bank
        coef_bank_reg #(
            .COEF_W (COEF_W),
            .UNITY  (UNITY)
        ) u_bank (
            .clk_i (clk_in),
            .rst_i (rst_in),
            .ld_i  (band_ld[b]),
            .d_i   (work_q[band_word0(b)*COEF_W +: BAND_W]),
            .q_o   (act_coefs[band_word0(b)*COEF_W +: BAND_W])
        );
    end

    assign pending     = full_q | ((state_q != ST_IDLE) && (state_q != ST_DONE));
    assign commit_done = (state_q == ST_DONE);
    assign superseded  = sup_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_coef_commit_ctrl.sv
// Randomized scoreboard bench for coef_commit_ctrl with a set-level reference model.
module tb_coef_commit_ctrl;
    localparam int COEF_W = 16;
    localparam int TO     = 8;
    localparam int SET_W  = 15*COEF_W;
    localparam int BW     = 5*COEF_W;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             upd_valid;
    logic [SET_W-1:0] upd_coefs;
    logic             sample_strobe;
    logic [2:0]       band_busy;
    logic [SET_W-1:0] act_coefs;
    logic             pending, commit_done, superseded, timeout_err;

    always #5 clk_in = ~clk_in;

    coef_commit_ctrl #(.COEF_W(COEF_W), .TIMEOUT_CYC(TO)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .upd_valid     (upd_valid),
        .upd_coefs     (upd_coefs),
        .sample_strobe (sample_strobe),
        .band_busy     (band_busy),
        .act_coefs     (act_coefs),
        .pending       (pending),
        .commit_done   (commit_done),
        .superseded    (superseded),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic [SET_W-1:0] set;
        int               done_cyc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    int               checks = 0, errors = 0;
    int               cyc = 0;
    int               sup_obs = 0, sup_exp = 0;
    logic [SET_W-1:0] m_shadow, m_act;
    bit               m_full, m_err;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [SET_W-1:0] got, input logic [SET_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [SET_W-1:0] passthru();
        logic [SET_W-1:0] r;
        r = '0;
        for (int k = 0; k < 15; k++) if (k % 5 == 0) r[k*16 +: 16] = 16'h4000;
        return r;
    endfunction

    // Bands below nb taken from nw, the rest from old
    function automatic logic [SET_W-1:0] mix(input logic [SET_W-1:0] nw, input logic [SET_W-1:0] old, input int nb);
        logic [SET_W-1:0] r;
        r = old;
        for (int b = 0; b < nb; b++) r[b*BW +: BW] = nw[b*BW +: BW];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rand_set(output logic [SET_W-1:0] s);
        for (int k = 0; k < 15; k++) s[k*16 +: 16] = 16'($urandom);
    endtask

    task automatic model_upd(input logic [SET_W-1:0] s);
        if (m_full) sup_exp++;
        m_shadow = s;
        m_full   = 1'b1;
    endtask

    // Monitor: every commit_done must match the oldest expected commit
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (superseded) sup_obs++;
            if (commit_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("act_at_done", act_coefs, e.set);
                    check("done_cycle", cyc, e.done_cyc);
                end
            end
        end
    end

    // One strobe pass; optional upd during the commit, sampled j edges after the strobe edge
    task automatic pass(input logic [2:0] busy, input bit mid_upd, input bit per_cycle);
        int               cost, j;
        logic [SET_W-1:0] ms, prev;
        cost = 0;
        for (int b = 0; b < 3; b++) cost += busy[b] ? TO : 1;
        j    = $urandom_range(0, cost);
        rand_set(ms);
        prev = m_act;
        band_busy = busy;
        if (m_full) begin
            exp_q.push_back('{m_shadow, cyc + 1 + cost});
            m_act  = m_shadow;
            m_full = 1'b0;
            if (busy != 3'b000) m_err = 1'b1;
        end
        for (int c = 0; c <= cost + 3; c++) begin
            sample_strobe = (c == 0);
            upd_valid     = mid_upd && (c == j);
            if (upd_valid) begin
                upd_coefs = ms;
                model_upd(ms);
            end
            if (per_cycle && c >= 1 && c <= 3) check("band_step", act_coefs, mix(m_act, prev, c - 1));
            if (per_cycle && c == 4) check("pending_at_done", pending, m_full);
            tick();
        end
        sample_strobe = 1'b0;
        upd_valid     = 1'b0;
        band_busy     = 3'b000;
    endtask

    task automatic txn(input int it);
        int               nupd;
        logic [2:0]       busy;
        logic [SET_W-1:0] s;
        nupd = (it == 0) ? 1 : (it == 1) ? 2 : $urandom_range(0, 2);
        for (int u = 0; u < nupd; u++) begin
            rand_set(s);
            if (it == 0) for (int k = 0; k < 15; k++) s[k*16 +: 16] = 16'(k + 1);
            upd_valid = 1'b1;
            upd_coefs = s;
            model_upd(s);
            tick();
            upd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat ($urandom_range(3, 6)) tick();
        check("pending_pre", pending, m_full);
        busy = (it == 0) ? 3'b000 : (it == 2) ? 3'b010 :
               ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        pass(busy, (it == 0) ? 1'b0 : (it == 3) ? 1'b1 : 1'($urandom_range(0, 1)), it == 0);
        repeat (2) tick();
        check("superseded_count", sup_obs, sup_exp);
        check("pending_post", pending, m_full);
        check("timeout_err", timeout_err, m_err);
    endtask

    initial begin
        logic [SET_W-1:0] s, prev;
        rst_in = 1'b1; upd_valid = 1'b0; upd_coefs = '0; sample_strobe = 1'b0; band_busy = 3'b000;
        m_full = 1'b0; m_err = 1'b0; m_shadow = '0; m_act = passthru();
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        tick();
        check("reset_act", act_coefs, passthru());
        check("reset_pending", pending, 0);
        check("reset_commit_done", commit_done, 0);
        check("reset_superseded", superseded, 0);
        check("reset_timeout_err", timeout_err, 0);

        for (int it = 0; it < 40; it++) txn(it);

        // Reset while the high band is held busy
        rand_set(s);
        upd_valid = 1'b1; upd_coefs = s; model_upd(s);
        tick();
        upd_valid = 1'b0;
        repeat (4) tick();
        prev = m_act;
        band_busy = 3'b100; sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        repeat (4) tick();
        check("pre_reset_bands", act_coefs, mix(m_shadow, prev, 2));
        rst_in = 1'b1;
        #1;
        check("mid_reset_act", act_coefs, passthru());
        check("mid_reset_pending", pending, 0);
        check("mid_reset_timeout_err", timeout_err, 0);
        check("mid_reset_commit_done", commit_done, 0);
        repeat (2) tick();
        rst_in = 1'b0; band_busy = 3'b000;
        m_full = 1'b0; m_err = 1'b0; m_act = passthru();
        repeat (12) tick();
        check("post_reset_pending", pending, 0);
        check("post_reset_act", act_coefs, passthru());
        check("outstanding_commits", exp_q.size(), 0);
        check("superseded_final", sup_obs, sup_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
